// File: rtl/enc_side_info_pipe_pkg.sv
// Shared types and default sizes for the encoder side-info delay line.
//   state_t      : control FSM states (IDLE / RUN / DRAIN)
//   DEF_*        : default parameter values used by the pipe and its bit counter
package enc_side_info_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_STAGE = 4;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_FRM_CNT_W = 32;
  localparam int DEF_BS_INC    = 1;

endpackage

// File: rtl/enc_side_info_pipe_bit_counter.sv
// Saturating per-LCU bitstream counter with capture and per-frame accumulation.
//   clk, rst      : clock, synchronous active-high reset
//   bs_val        : one bitstream unit emitted this cycle (adds BS_INC)
//   capture       : LCU done; latch count (including same-cycle bs_val), restart
//   accum_en      : add the captured count into the frame total
//   frame_clr     : clear the frame total (wins over accumulation)
//   rc_bitnum     : count of the last captured LCU
//   bitnum_sat    : last captured count hit its ceiling at some point
//   frame_bitnum  : saturating sum of captured counts for the current frame
module enc_side_info_pipe_bit_counter
  import enc_side_info_pipe_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FRM_CNT_W = DEF_FRM_CNT_W,
  parameter int BS_INC    = DEF_BS_INC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bs_val,
  input  logic                 capture,
  input  logic                 accum_en,
  input  logic                 frame_clr,
  output logic [CNT_W-1:0]     rc_bitnum,
  output logic                 bitnum_sat,
  output logic [FRM_CNT_W-1:0] frame_bitnum
);

  localparam logic [CNT_W:0] INC_EXT = (CNT_W+1)'(BS_INC);

  // Clamp a one-bit-wider sum; the MSB of the result flags that clamping happened.
  function automatic logic [CNT_W:0] sat_cnt(input logic [CNT_W:0] sum);
    if (sum[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
    return sum;
  endfunction

  function automatic logic [FRM_CNT_W-1:0] sat_frm(input logic [FRM_CNT_W:0] sum);
    if (sum[FRM_CNT_W]) return {FRM_CNT_W{1'b1}};
    return sum[FRM_CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0]   cnt;
  logic               cnt_sat;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W:0]     cnt_clamped;
  logic [FRM_CNT_W:0] frm_sum;

  always_comb begin
    cnt_sum     = {1'b0, cnt} + (bs_val ? INC_EXT : '0);
    cnt_clamped = sat_cnt(cnt_sum);
    frm_sum     = {1'b0, frame_bitnum} + (FRM_CNT_W+1)'(cnt_clamped[CNT_W-1:0]);
  end

  // Counter, capture and frame accumulation all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      cnt_sat      <= 1'b0;
      rc_bitnum    <= '0;
      bitnum_sat   <= 1'b0;
      frame_bitnum <= '0;
    end else begin
      if (capture) begin
        rc_bitnum  <= cnt_clamped[CNT_W-1:0];
        bitnum_sat <= cnt_sat | cnt_clamped[CNT_W];
        cnt        <= '0;
        cnt_sat    <= 1'b0;
      end else begin
        cnt        <= cnt_clamped[CNT_W-1:0];
        cnt_sat    <= cnt_sat | cnt_clamped[CNT_W];
      end
      if (frame_clr) begin
        frame_bitnum <= '0;
      end else if (capture && accum_en) begin
        frame_bitnum <= sat_frm(frm_sum);
      end
    end
  end

endmodule

// File: rtl/enc_side_info_pipe.sv
// Per-LCU side-info delay line with frame control and bit accounting.
//   clk, rst           : clock, synchronous active-high reset
//   enc_done_i         : LCU done; advances the delay line in RUN/DRAIN
//   frame_start_i      : start (or restart) a frame; clears valids and frame total
//   frame_end_i        : last LCU of the frame; RUN -> DRAIN
//   info_i, info_val_i : side info of the LCU finishing now and its valid
//   bs_val_i           : one bitstream unit emitted this cycle
//   stage_info_o       : stage k at [k*DATA_W +: DATA_W] (info delayed k+1 LCUs)
//   stage_val_o        : valid of stage k
//   rc_actual_bitnum_o : bit count of last completed LCU
//   bitnum_sat_o       : that count saturated
//   frame_bitnum_o     : accumulated bits of the current frame
//   busy_o             : FSM not idle
//   drain_done_o       : one-cycle pulse after the final drain shift
module enc_side_info_pipe
  import enc_side_info_pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FRM_CNT_W = DEF_FRM_CNT_W,
  parameter int BS_INC    = DEF_BS_INC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enc_done_i,
  input  logic                        frame_start_i,
  input  logic                        frame_end_i,
  input  logic [DATA_W-1:0]           info_i,
  input  logic                        info_val_i,
  input  logic                        bs_val_i,
  output logic [NUM_STAGE*DATA_W-1:0] stage_info_o,
  output logic [NUM_STAGE-1:0]        stage_val_o,
  output logic [CNT_W-1:0]            rc_actual_bitnum_o,
  output logic                        bitnum_sat_o,
  output logic [FRM_CNT_W-1:0]        frame_bitnum_o,
  output logic                        busy_o,
  output logic                        drain_done_o
);

  localparam int DC_W = $clog2(NUM_STAGE + 1);

  state_t            state, state_nxt;
  logic [DC_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic              drain_done_nxt;
  logic              active;
  logic              shift_en;
  logic              vld_in;

  logic [DATA_W-1:0] info_p [NUM_STAGE];
  logic              vld_p  [NUM_STAGE];

  assign active   = (state != ST_IDLE);
  // A same-cycle frame_start wins: valids clear and nothing shifts.
  assign shift_en = enc_done_i && active && !frame_start_i;
  // Drain shifts push bubbles in behind the last real LCU.
  assign vld_in   = info_val_i && (state == ST_RUN);

  always_comb begin
    state_nxt      = state;
    drain_cnt_nxt  = drain_cnt;
    drain_done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start_i) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (frame_start_i) begin
          state_nxt = ST_RUN;
        end else if (frame_end_i) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DC_W'(NUM_STAGE);
        end
      end
      ST_DRAIN: begin
        if (frame_start_i) begin
          state_nxt     = ST_RUN;
          drain_cnt_nxt = '0;
        end else if (enc_done_i) begin
          drain_cnt_nxt = drain_cnt - DC_W'(1);
          if (drain_cnt == DC_W'(1)) begin
            state_nxt      = ST_IDLE;
            drain_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      drain_cnt    <= '0;
      drain_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      drain_done_o <= drain_done_nxt;
    end
  end

  assign busy_o = active;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic [DATA_W-1:0] info_src;
    logic              vld_src;

    if (k == 0) begin : g_head
      assign info_src = info_i;
      assign vld_src  = vld_in;
    end else begin : g_tail
      assign info_src = info_p[k-1];
      assign vld_src  = vld_p[k-1];
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        info_p[k] <= '0;
        vld_p[k]  <= 1'b0;
      end else begin
        if (shift_en) info_p[k] <= info_src;
        if (frame_start_i)  vld_p[k] <= 1'b0;
        else if (shift_en)  vld_p[k] <= vld_src;
      end
    end

    assign stage_info_o[k*DATA_W +: DATA_W] = info_p[k];
    assign stage_val_o[k]                   = vld_p[k];
  end

  enc_side_info_pipe_bit_counter #(
    .CNT_W     (CNT_W),
    .FRM_CNT_W (FRM_CNT_W),
    .BS_INC    (BS_INC)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .bs_val       (bs_val_i),
    .capture      (enc_done_i),
    .accum_en     (active),
    .frame_clr    (frame_start_i),
    .rc_bitnum    (rc_actual_bitnum_o),
    .bitnum_sat   (bitnum_sat_o),
    .frame_bitnum (frame_bitnum_o)
  );

endmodule

// File: tb/tb_enc_side_info_pipe.sv
module tb_enc_side_info_pipe;

  localparam int DATA_W    = 8;
  localparam int NUM_STAGE = 4;
  localparam int CNT_W     = 8;
  localparam int FRM_CNT_W = 32;
  localparam int BS_INC    = 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        enc_done_i;
  logic                        frame_start_i;
  logic                        frame_end_i;
  logic [DATA_W-1:0]           info_i;
  logic                        info_val_i;
  logic                        bs_val_i;
  logic [NUM_STAGE*DATA_W-1:0] stage_info_o;
  logic [NUM_STAGE-1:0]        stage_val_o;
  logic [CNT_W-1:0]            rc_actual_bitnum_o;
  logic                        bitnum_sat_o;
  logic [FRM_CNT_W-1:0]        frame_bitnum_o;
  logic                        busy_o;
  logic                        drain_done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc_side_info_pipe #(
    .DATA_W    (DATA_W),
    .NUM_STAGE (NUM_STAGE),
    .CNT_W     (CNT_W),
    .FRM_CNT_W (FRM_CNT_W),
    .BS_INC    (BS_INC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enc_done_i         (enc_done_i),
    .frame_start_i      (frame_start_i),
    .frame_end_i        (frame_end_i),
    .info_i             (info_i),
    .info_val_i         (info_val_i),
    .bs_val_i           (bs_val_i),
    .stage_info_o       (stage_info_o),
    .stage_val_o        (stage_val_o),
    .rc_actual_bitnum_o (rc_actual_bitnum_o),
    .bitnum_sat_o       (bitnum_sat_o),
    .frame_bitnum_o     (frame_bitnum_o),
    .busy_o             (busy_o),
    .drain_done_o       (drain_done_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then return pulses to idle.
  task automatic drive(input logic fs, input logic fe, input logic ed,
                       input logic [DATA_W-1:0] inf, input logic iv, input logic bs);
    frame_start_i = fs;
    frame_end_i   = fe;
    enc_done_i    = ed;
    info_i        = inf;
    info_val_i    = iv;
    bs_val_i      = bs;
    step();
    frame_start_i = 1'b0;
    frame_end_i   = 1'b0;
    enc_done_i    = 1'b0;
    info_i        = '0;
    info_val_i    = 1'b0;
    bs_val_i      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start_i = 1'b0; frame_end_i = 1'b0; enc_done_i = 1'b0;
    info_i = '0; info_val_i = 1'b0; bs_val_i = 1'b0;
    #1;
    step(); step();

    // Reset state
    check("rst_info", stage_info_o, 32'h0);
    check("rst_val", stage_val_o, 4'h0);
    check("rst_rc", rc_actual_bitnum_o, 8'd0);
    check("rst_frame", frame_bitnum_o, 32'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_dd", drain_done_o, 1'b0);
    rst = 1'b0;

    // 1: fill the line; last LCU also carries frame_end
    drive(1, 0, 0, 8'h00, 0, 0);
    check("fs_busy", busy_o, 1'b1);
    drive(0, 0, 1, 8'h11, 1, 0);
    drive(0, 0, 1, 8'h22, 1, 0);
    drive(0, 0, 1, 8'h33, 1, 0);
    drive(0, 1, 1, 8'h44, 1, 0);
    check("fill_info", stage_info_o, 32'h11223344);
    check("fill_val", stage_val_o, 4'hF);
    check("fill_busy", busy_o, 1'b1);

    // 2: drain with bubbles
    drive(0, 0, 1, 8'h55, 1, 0);
    check("drain1_val", stage_val_o, 4'hE);
    check("drain1_dd", drain_done_o, 1'b0);
    drive(0, 0, 1, 8'h66, 1, 0);
    check("drain2_val", stage_val_o, 4'hC);
    drive(0, 0, 1, 8'h77, 1, 0);
    check("drain3_val", stage_val_o, 4'h8);
    drive(0, 0, 1, 8'h88, 1, 0);
    check("drain4_val", stage_val_o, 4'h0);
    check("drain4_info", stage_info_o, 32'h55667788);
    check("drain_done_pulse", drain_done_o, 1'b1);
    check("drain_busy", busy_o, 1'b0);
    drive(0, 0, 0, 8'h00, 0, 0);
    check("drain_done_once", drain_done_o, 1'b0);
    drive(0, 0, 1, 8'h99, 1, 0);
    check("idle_noshift_info", stage_info_o, 32'h55667788);
    check("idle_noshift_val", stage_val_o, 4'h0);

    // 3: saturation then a normal LCU with same-cycle bs_val
    drive(1, 0, 0, 8'h00, 0, 0);
    check("fs2_frame", frame_bitnum_o, 32'd0);
    bs_val_i = 1'b1;
    repeat (300) step();
    bs_val_i = 1'b0;
    drive(0, 0, 1, 8'hA1, 1, 0);
    check("sat_rc", rc_actual_bitnum_o, 8'd255);
    check("sat_flag", bitnum_sat_o, 1'b1);
    check("sat_frame", frame_bitnum_o, 32'd255);
    check("sat_info", stage_info_o, 32'h667788A1);
    check("sat_val", stage_val_o, 4'h1);
    bs_val_i = 1'b1;
    repeat (10) step();
    drive(0, 0, 1, 8'hB2, 1, 1);
    check("lcu2_rc", rc_actual_bitnum_o, 8'd11);
    check("lcu2_sat", bitnum_sat_o, 1'b0);
    check("lcu2_frame", frame_bitnum_o, 32'd266);
    check("lcu2_val", stage_val_o, 4'h3);

    // 4: frame_start beats a same-cycle enc_done
    drive(1, 0, 1, 8'hC3, 1, 0);
    check("abort_val", stage_val_o, 4'h0);
    check("abort_info", stage_info_o, 32'h7788A1B2);
    check("abort_frame", frame_bitnum_o, 32'd0);
    check("abort_busy", busy_o, 1'b1);
    drive(0, 0, 1, 8'hD4, 1, 0);
    check("abort_run_val", stage_val_o, 4'h1);
    check("abort_run_info", stage_info_o, 32'h88A1B2D4);

    // 5: reset in DRAIN with two shifts left
    drive(0, 1, 0, 8'h00, 0, 0);
    drive(0, 0, 1, 8'hE5, 1, 0);
    drive(0, 0, 1, 8'hF6, 1, 0);
    check("pre_rst_val", stage_val_o, 4'h4);
    check("pre_rst_info", stage_info_o, 32'hB2D4E5F6);
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    check("mid_rst_info", stage_info_o, 32'h0);
    check("mid_rst_val", stage_val_o, 4'h0);
    check("mid_rst_frame", frame_bitnum_o, 32'd0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_dd", drain_done_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'h12, 1, 0);
      check("post_rst_dd", drain_done_o, 1'b0);
      check("post_rst_info", stage_info_o, 32'h0);
      check("post_rst_busy", busy_o, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
